// File: rtl/shift_add_multiplier.sv
// Iterative signed 32x32 shift-add multiplier.
// One multiplier bit is retired per cycle. The bit-31 step subtracts the
// shifted multiplicand because that bit carries weight -2^31 in two's
// complement. The block returns the low 32 product bits, a signed-overflow
// flag and a single-cycle ready pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for ctrl_MULT; outputs hold the last result
// S_RUN  | one partial-product step per edge, count = 0..31
// S_DONE | one cycle: data_resultRDY=1, result/exception valid
module shift_add_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_mcand_a;
    logic [WIDTH-1:0]       r_mcand_b;
    logic [WIDTH-1:0]       r_result;
    logic                   r_exc;
    logic                   r_rdy;
    logic                   r_busy;

    logic [2*WIDTH-1:0]     w_addend;
    logic                   w_last;
    logic                   w_bit;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic                   w_exc_next;

    // Partial-product step for the current count; also flags the final step
    always_comb begin
        w_addend   = {{WIDTH{r_mcand_a[WIDTH-1]}}, r_mcand_a} << r_count;
        w_last     = (r_count == CNT_W'(WIDTH - 1));
        w_bit      = r_mcand_b[r_count];
        w_acc_next = r_acc;
        if (w_bit) begin
            if (w_last) begin
                w_acc_next = r_acc - w_addend;
            end else begin
                w_acc_next = r_acc + w_addend;
            end
        end
        // Overflow when the upper half is not a pure sign extension of bit 31
        w_exc_next = (w_acc_next[2*WIDTH-1:WIDTH] != {WIDTH{w_acc_next[WIDTH-1]}});
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand_a <= '0;
            r_mcand_b <= '0;
            r_result  <= '0;
            r_exc     <= 1'b0;
            r_rdy     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rdy <= 1'b0;
                    if (ctrl_MULT) begin
                        r_mcand_a <= data_A;
                        r_mcand_b <= data_B;
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // ctrl_MULT is deliberately not looked at here
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_exc    <= w_exc_next;
                        r_rdy    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_rdy <= 1'b0;
                    if (ctrl_MULT) begin
                        r_mcand_a <= data_A;
                        r_mcand_b <= data_B;
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier with hand-computed products.
module tb_shift_add_multiplier;

    logic        clock;
    logic        resetn;
    logic        ctrl_MULT;
    logic [31:0] data_A;
    logic [31:0] data_B;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_multiplier #(.WIDTH(32), .CNT_W(5)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .data_A         (data_A),
        .data_B         (data_B),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; issues the start edge and scrambles operands
    task automatic start(input logic [31:0] a, input logic [31:0] b, input string tag);
        data_A    = a;
        data_B    = b;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        data_A    = $urandom;
        data_B    = $urandom;
        check({tag, " busy after start"}, 64'(busy), 64'd1);
        check({tag, " rdy after start"}, 64'(data_resultRDY), 64'd0);
    endtask

    // Waits for the RDY pulse; n0 is the number of edges already elapsed
    // since the start edge. Optionally chains a back-to-back start in DONE.
    task automatic wait_rdy(input int n0, input logic [31:0] er, input logic ee,
                            input string tag, input bit chain,
                            input logic [31:0] na, input logic [31:0] nb);
        int  n;
        bit  seen;
        n    = n0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clock);
            n++;
            if (data_resultRDY === 1'b1) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(n), 64'd32);
        check({tag, " result"}, 64'(data_result), 64'(er));
        check({tag, " exception"}, 64'(data_exception), 64'(ee));
        check({tag, " busy in done"}, 64'(busy), 64'd0);
        if (chain) begin
            start(na, nb, {tag, " b2b"});
        end else begin
            @(negedge clock);
            check({tag, " single pulse"}, 64'(data_resultRDY), 64'd0);
            @(negedge clock);
            check({tag, " result hold"}, 64'(data_result), 64'(er));
        end
    endtask

    initial begin
        int rdy_seen;
        resetn    = 1'b0;
        ctrl_MULT = 1'b0;
        data_A    = 32'd0;
        data_B    = 32'd0;
        repeat (2) @(negedge clock);
        check("reset result", 64'(data_result), 64'd0);
        check("reset exc", 64'(data_exception), 64'd0);
        check("reset rdy", 64'(data_resultRDY), 64'd0);
        check("reset busy", 64'(busy), 64'd0);

        // Reset wins over a simultaneous start
        ctrl_MULT = 1'b1;
        data_A    = 32'd3;
        data_B    = 32'd3;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        resetn    = 1'b1;
        @(negedge clock);
        check("reset beats start busy", 64'(busy), 64'd0);

        // 3 * 4
        start(32'd3, 32'd4, "t1");
        wait_rdy(0, 32'd12, 1'b0, "t1", 1'b0, 32'd0, 32'd0);

        // -7 * 6 = -42
        start(32'hFFFF_FFF9, 32'd6, "t2");
        wait_rdy(0, 32'hFFFF_FFD6, 1'b0, "t2", 1'b0, 32'd0, 32'd0);

        // 2^16 * 2^16 = 2^32
        start(32'h0001_0000, 32'h0001_0000, "t3");
        wait_rdy(0, 32'h0000_0000, 1'b1, "t3", 1'b0, 32'd0, 32'd0);

        // -2^31 * -1 = 2^31 overflows; chain -2^31 * 1 back-to-back
        start(32'h8000_0000, 32'hFFFF_FFFF, "t4a");
        wait_rdy(0, 32'h8000_0000, 1'b1, "t4a", 1'b1, 32'h8000_0000, 32'd1);
        wait_rdy(0, 32'h8000_0000, 1'b0, "t4b", 1'b0, 32'd0, 32'd0);

        // -2^31 * -2^31 = 2^62
        start(32'h8000_0000, 32'h8000_0000, "tmin");
        wait_rdy(0, 32'h0000_0000, 1'b1, "tmin", 1'b0, 32'd0, 32'd0);

        // 5 * 5 with an ignored start pulse at step 10
        start(32'd5, 32'd5, "t5");
        repeat (9) @(negedge clock);
        data_A    = 32'd9;
        data_B    = 32'd9;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        check("t5 rdy mid-run", 64'(data_resultRDY), 64'd0);
        wait_rdy(10, 32'd25, 1'b0, "t5", 1'b0, 32'd0, 32'd0);

        // Reset mid-run aborts with no RDY
        start(32'd5, 32'd5, "t6");
        repeat (14) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check("t6 abort result", 64'(data_result), 64'd0);
        check("t6 abort exc", 64'(data_exception), 64'd0);
        check("t6 abort rdy", 64'(data_resultRDY), 64'd0);
        check("t6 abort busy", 64'(busy), 64'd0);
        resetn   = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check("t6 no rdy after abort", 64'(rdy_seen), 64'd0);

        // 2 * -3 = -6
        start(32'd2, 32'hFFFF_FFFD, "t6b");
        wait_rdy(0, 32'hFFFF_FFFA, 1'b0, "t6b", 1'b0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
